// File: rtl/traffic_light_ctrl_timed_if.sv
// Sensor, timebase and lamp bundle between the intersection controller and its surroundings.
// The slave side is the controller; the master side drives sensors and watches the lamps.
interface traffic_light_ctrl_timed_if;
  logic       tick;
  logic       Sa;
  logic       Sb;
  logic       flash;
  logic       Ra;
  logic       Ya;
  logic       Ga;
  logic       Rb;
  logic       Yb;
  logic       Gb;
  logic [2:0] state;

  modport master (
    output tick, Sa, Sb, flash,
    input  Ra, Ya, Ga, Rb, Yb, Gb, state
  );

  modport slave (
    input  tick, Sa, Sb, flash,
    output Ra, Ya, Ga, Rb, Yb, Gb, state
  );
endinterface

// File: rtl/traffic_light_ctrl_timed.sv
// Two-street intersection controller with timed phases, all-red clearance,
// bounded side-street green extension and a flashing night mode.
module traffic_light_ctrl_timed #(
  parameter int CNT_W       = 8,
  parameter int GREEN_A_MIN = 60,
  parameter int GREEN_B     = 50,
  parameter int GREEN_B_EXT = 10,
  parameter int YELLOW_T    = 5,
  parameter int ALL_RED_T   = 2,
  parameter int MAX_EXT     = 4
) (
  input logic                     clk,
  input logic                     reset,
  traffic_light_ctrl_timed_if.slave tl
);

  typedef enum logic [2:0] {
    A_GREEN  = 3'd0,
    A_YELLOW = 3'd1,
    AR_AB    = 3'd2,
    B_GREEN  = 3'd3,
    B_YELLOW = 3'd4,
    AR_BA    = 3'd5,
    FLASH    = 3'd6
  } state_t;

  // Durations are stored as D-1 so a D of 2^CNT_W still fits the timer.
  localparam logic [CNT_W-1:0] GA_M1   = CNT_W'(GREEN_A_MIN - 1);
  localparam logic [CNT_W-1:0] GB_M1   = CNT_W'(GREEN_B - 1);
  localparam logic [CNT_W-1:0] GBX_M1  = CNT_W'(GREEN_B_EXT - 1);
  localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_M1   = CNT_W'(ALL_RED_T - 1);
  localparam logic [CNT_W-1:0] EXT_SAT = '1;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] tmr;
  logic [CNT_W-1:0] ext;
  logic [CNT_W-1:0] dur_m1;
  logic             min_done;
  logic             phase;
  logic             expire;
  logic             extend;
  logic             ext_ok;
  logic             entering;
  logic [5:0]       lamps;

  always_comb begin
    dur_m1 = AR_M1;
    case (state_q)
      A_GREEN:            dur_m1 = GA_M1;
      A_YELLOW, B_YELLOW: dur_m1 = YEL_M1;
      AR_AB, AR_BA:       dur_m1 = AR_M1;
      B_GREEN:            dur_m1 = (ext == '0) ? GB_M1 : GBX_M1;
      default:            dur_m1 = AR_M1;
    endcase
  end

  assign expire   = tl.tick && (tmr == dur_m1);
  assign ext_ok   = (MAX_EXT == 0) || (int'(ext) < MAX_EXT);
  assign entering = (state_d != state_q);

  always_comb begin
    state_d = state_q;
    extend  = 1'b0;
    case (state_q)
      A_GREEN: begin
        if (tl.flash || ((min_done || expire) && tl.Sb)) state_d = A_YELLOW;
      end
      A_YELLOW: begin
        if (expire) state_d = AR_AB;
      end
      AR_AB: begin
        if (expire) state_d = tl.flash ? FLASH : B_GREEN;
      end
      B_GREEN: begin
        if (tl.flash) begin
          state_d = B_YELLOW;
        end else if (expire) begin
          if (tl.Sb && !tl.Sa && ext_ok) extend = 1'b1;
          else                           state_d = B_YELLOW;
        end
      end
      B_YELLOW: begin
        if (expire) state_d = AR_BA;
      end
      AR_BA: begin
        if (expire) state_d = tl.flash ? FLASH : A_GREEN;
      end
      FLASH: begin
        if (!tl.flash) state_d = AR_BA;
      end
      default: state_d = A_GREEN;
    endcase
  end

  // Every per-phase register restarts whenever the state changes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= A_GREEN;
      tmr      <= '0;
      ext      <= '0;
      min_done <= 1'b0;
      phase    <= 1'b0;
    end else begin
      state_q <= state_d;

      if (entering || extend)                tmr <= '0;
      else if (tl.tick && (tmr < dur_m1))    tmr <= tmr + CNT_W'(1);

      if (entering)                          min_done <= 1'b0;
      else if ((state_q == A_GREEN) && expire) min_done <= 1'b1;

      if (entering)                          ext <= '0;
      else if (extend && (ext != EXT_SAT))   ext <= ext + CNT_W'(1);

      if (entering)                          phase <= 1'b0;
      else if ((state_q == FLASH) && tl.tick) phase <= ~phase;
    end
  end

  // Lamp order {Ra, Ya, Ga, Rb, Yb, Gb}; an illegal encoding shows all-red.
  always_comb begin
    lamps = 6'b000000;
    case (state_q)
      A_GREEN:      lamps = 6'b001100;
      A_YELLOW:     lamps = 6'b010100;
      AR_AB, AR_BA: lamps = 6'b100100;
      B_GREEN:      lamps = 6'b100001;
      B_YELLOW:     lamps = 6'b100010;
      FLASH:        lamps = {1'b0, phase, 1'b0, phase, 2'b00};
      default:      lamps = 6'b100100;
    endcase
  end

  assign tl.Ra    = lamps[5];
  assign tl.Ya    = lamps[4];
  assign tl.Ga    = lamps[3];
  assign tl.Rb    = lamps[2];
  assign tl.Yb    = lamps[1];
  assign tl.Gb    = lamps[0];
  assign tl.state = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl_timed.sv
// Directed bench for traffic_light_ctrl_timed with short phase durations; a second
// instance with unlimited extensions runs alongside on the same inputs.
module tb_traffic_light_ctrl_timed;

  localparam logic [5:0] L_AG  = 6'b001100;
  localparam logic [5:0] L_AY  = 6'b010100;
  localparam logic [5:0] L_AR  = 6'b100100;
  localparam logic [5:0] L_BG  = 6'b100001;
  localparam logic [5:0] L_BY  = 6'b100010;
  localparam logic [5:0] L_OFF = 6'b000000;

  logic clk = 1'b0;
  logic reset;
  logic tick;
  logic sa;
  logic sb;
  logic flash_r;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_violations = 0;
  bit mon_en   = 1'b0;
  bit tick_div = 1'b0;
  int div_cnt  = 0;

  traffic_light_ctrl_timed_if tl ();
  traffic_light_ctrl_timed_if tl0 ();

  assign tl.tick   = tick;
  assign tl.Sa     = sa;
  assign tl.Sb     = sb;
  assign tl.flash  = flash_r;
  assign tl0.tick  = tick;
  assign tl0.Sa    = sa;
  assign tl0.Sb    = sb;
  assign tl0.flash = flash_r;

  traffic_light_ctrl_timed #(
    .CNT_W(8), .GREEN_A_MIN(6), .GREEN_B(5), .GREEN_B_EXT(2),
    .YELLOW_T(2), .ALL_RED_T(1), .MAX_EXT(2)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .tl    (tl)
  );

  traffic_light_ctrl_timed #(
    .CNT_W(8), .GREEN_A_MIN(6), .GREEN_B(5), .GREEN_B_EXT(2),
    .YELLOW_T(2), .ALL_RED_T(1), .MAX_EXT(0)
  ) u_dut_unl (
    .clk   (clk),
    .reset (reset),
    .tl    (tl0)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [5:0] lamps_of();
    return {tl.Ra, tl.Ya, tl.Ga, tl.Rb, tl.Yb, tl.Gb};
  endfunction

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, actual, actual, expected, expected);
    end
  endtask

  // Advances to the next sampling point; optionally flags state changes on tick=0 cycles.
  task automatic next_cycle();
    logic [2:0] cur_state;
    logic       cur_tick;
    logic       cur_reset;
    cur_state = tl.state;
    cur_tick  = tick;
    cur_reset = reset;
    @(negedge clk);
    if (mon_en && !cur_reset && !cur_tick && (tl.state != cur_state)) tick_violations++;
    if (tick_div) begin
      div_cnt = (div_cnt + 1) % 3;
      tick    = (div_cnt == 2);
    end
  endtask

  task automatic apply_stimulus(input logic a, input logic b, input logic fl);
    sa      = a;
    sb      = b;
    flash_r = fl;
    reset   = 1'b1;
    next_cycle();
    reset   = 1'b0;
  endtask

  task automatic expect_phase(input string tag, input logic [2:0] s, input logic [5:0] lamps,
                              input int len, input int sa_at);
    int n;
    check_output({tag, "_state"}, 32'(tl.state), 32'(s));
    check_output({tag, "_lamps"}, 32'(lamps_of()), 32'(lamps));
    n = 0;
    while ((tl.state == s) && (n < 1000)) begin
      if (n == sa_at) sa = 1'b1;
      n++;
      next_cycle();
    end
    check_output({tag, "_len"}, 32'(n), 32'(len));
  endtask

  initial begin
    int n;
    tick = 1'b1;

    // Reset state, then A holds green while B is empty.
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("rst_state", 32'(tl.state), 32'd0);
    check_output("rst_lamps", 32'(lamps_of()), 32'(L_AG));
    check_output("rst_state_unl", 32'(tl0.state), 32'd0);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if ((tl.state == 3'd0) && tl.Ga) n++;
      next_cycle();
    end
    check_output("s1_ga_hold", 32'(n), 32'd30);
    sa = 1'b1;
    sb = 1'b1;
    next_cycle();
    expect_phase("s1_ay", 3'd1, L_AY, 2, -1);
    expect_phase("s1_arab", 3'd2, L_AR, 1, -1);
    expect_phase("s1_bg", 3'd3, L_BG, 5, -1);
    expect_phase("s1_by", 3'd4, L_BY, 2, -1);
    expect_phase("s1_arba", 3'd5, L_AR, 1, -1);
    check_output("s1_back_a", 32'(tl.state), 32'd0);

    // Side street busy, main empty: two extensions then yellow.
    apply_stimulus(1'b0, 1'b1, 1'b0);
    expect_phase("s2_ag", 3'd0, L_AG, 6, -1);
    expect_phase("s2_ay", 3'd1, L_AY, 2, -1);
    expect_phase("s2_arab", 3'd2, L_AR, 1, -1);
    expect_phase("s2_bg", 3'd3, L_BG, 9, -1);
    expect_phase("s2_by", 3'd4, L_BY, 2, -1);
    expect_phase("s2_arba", 3'd5, L_AR, 1, -1);
    check_output("s2_back_a", 32'(tl.state), 32'd0);

    // Unlimited extensions keep B green well past 100 cycles.
    apply_stimulus(1'b0, 1'b1, 1'b0);
    n = 0;
    while ((tl0.state != 3'd3) && (n < 50)) begin
      n++;
      next_cycle();
    end
    check_output("s2u_reach_bg", 32'(tl0.state), 32'd3);
    n = 0;
    while ((tl0.state == 3'd3) && (n < 600)) begin
      n++;
      next_cycle();
    end
    check_output("s2u_bg_len", 32'(n), 32'd600);

    // Main street car arrives during the first extension: no second extension.
    apply_stimulus(1'b0, 1'b1, 1'b0);
    expect_phase("s3_ag", 3'd0, L_AG, 6, -1);
    expect_phase("s3_ay", 3'd1, L_AY, 2, -1);
    expect_phase("s3_arab", 3'd2, L_AR, 1, -1);
    expect_phase("s3_bg", 3'd3, L_BG, 7, 5);
    expect_phase("s3_by", 3'd4, L_BY, 2, -1);

    // Slow timebase: one tick every third cycle.
    apply_stimulus(1'b0, 1'b1, 1'b0);
    tick_div = 1'b1;
    div_cnt  = 0;
    tick     = 1'b0;
    mon_en   = 1'b1;
    expect_phase("s4_ag", 3'd0, L_AG, 18, -1);
    expect_phase("s4_ay", 3'd1, L_AY, 6, -1);
    expect_phase("s4_arab", 3'd2, L_AR, 3, -1);
    mon_en   = 1'b0;
    tick_div = 1'b0;
    tick     = 1'b1;
    check_output("s4_tick0_changes", 32'(tick_violations), 32'd0);

    // Night mode requested during B green.
    apply_stimulus(1'b1, 1'b1, 1'b0);
    expect_phase("s5_ag", 3'd0, L_AG, 6, -1);
    expect_phase("s5_ay", 3'd1, L_AY, 2, -1);
    expect_phase("s5_arab", 3'd2, L_AR, 1, -1);
    check_output("s5_bg_state", 32'(tl.state), 32'd3);
    flash_r = 1'b1;
    next_cycle();
    expect_phase("s5_by", 3'd4, L_BY, 2, -1);
    expect_phase("s5_arba", 3'd5, L_AR, 1, -1);
    check_output("s5_flash_state", 32'(tl.state), 32'd6);
    for (int i = 0; i < 4; i++) begin
      check_output($sformatf("s5_flash_lamps%0d", i), 32'(lamps_of()),
                   32'((i % 2 == 1) ? L_AY : L_OFF));
      next_cycle();
    end
    flash_r = 1'b0;
    next_cycle();
    expect_phase("s5_exit_arba", 3'd5, L_AR, 1, -1);
    expect_phase("s5_ag_min", 3'd0, L_AG, 6, -1);

    // Reset mid B yellow restarts the full A minimum.
    apply_stimulus(1'b1, 1'b1, 1'b0);
    expect_phase("s6_ag", 3'd0, L_AG, 6, -1);
    expect_phase("s6_ay", 3'd1, L_AY, 2, -1);
    expect_phase("s6_arab", 3'd2, L_AR, 1, -1);
    expect_phase("s6_bg", 3'd3, L_BG, 5, -1);
    check_output("s6_by_state", 32'(tl.state), 32'd4);
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    expect_phase("s6_ag_after_rst", 3'd0, L_AG, 6, -1);
    check_output("s6_ay_after", 32'(tl.state), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
